bist_misr: RTL
==============

Name: bist_misr

Overview:
- Response compactor and run controller for the LFSR-driven BIST path.
- Sits directly downstream of the LFSR pattern generator and the circuit under test (CUT).
- Drives the LFSR seed-load strobe, then folds CUT responses into a multiple-input signature register (MISR) for a programmed number of patterns.
- Shifts the final signature out serially and flags pass/fail against a golden value.

Parameters:
- NBIT, 4, width of MISR, response bus and golden signature.
- TAPS, 4'b1100, feedback tap mask; feedback bit = XOR of (sig & TAPS). The default matches the generator polynomial (bits 3 and 2).
- CNT_W, 8, width of the pattern counter and npat.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a BIST run; sampled only in IDLE or DONE
- npat  input  CNT_W  number of responses to compact; sampled at start
- resp_in  input  NBIT  CUT response vector
- resp_valid  input  1  resp_in is valid this cycle
- golden  input  NBIT  expected signature; compared on entry to DONE
- lfsr_rst  output  1  seed-load strobe to the upstream LFSR
- busy  output  1  high in SEED, RUN and SHIFT
- signature  output  NBIT  current MISR contents
- scan_out  output  1  serial signature bit, MSB first
- scan_valid  output  1  scan_out carries a signature bit
- done  output  1  run complete; held high until the next start or rst
- pass  output  1  signature == golden; meaningful only while done=1

Behaviour:
- Reset: state=IDLE, sig=0, count=0, shreg=0. All outputs are 0 (lfsr_rst, busy, signature, scan_out, scan_valid, done, pass). rst dominates start.
- States: IDLE, SEED, RUN, SHIFT, DONE.
- IDLE/DONE to SEED: on start=1 at edge k.
  - State is SEED at k+1; npat is latched; sig and count are cleared; done and pass are cleared.
- SEED: lasts exactly 1 cycle with lfsr_rst=1; lfsr_rst is 0 in every other state. Next state:
  - RUN if latched npat != 0;
  - SHIFT if npat == 0 (sig=0 is loaded into shreg).
- RUN: each cycle with resp_valid=1:
  - sig <= {sig[NBIT-2:0], ^(sig & TAPS)} ^ resp_in;
  - count <= count+1.
- RUN stalls:
  - resp_valid=0 leaves sig and count unchanged.
  - There is no timeout.
  - resp_in is ignored outside RUN.
- RUN to SHIFT: on the valid cycle where count == npat-1.
  - The final folded value is written to both sig and shreg.
  - Exactly npat responses are compacted.
- SHIFT: exactly NBIT cycles.
  - scan_valid=1; scan_out = shreg[NBIT-1].
  - shreg shifts left, zero-filling, each cycle.
  - The signature output stays stable during SHIFT.
- SHIFT to DONE: after the NBIT-th bit. The registered pass is set to (sig == golden).
  - done=1, busy=0, scan_valid=0.
  - A new start restarts the run through SEED.
- start is ignored in SEED, RUN and SHIFT.
- A mid-run rst aborts immediately and returns everything to the reset values; no partial done.
- The counter is CNT_W bits. npat = 2^CNT_W-1 is the maximum and must not wrap.
- busy and done are never high together.

Test Plan:
1. rst, then start with npat=4, golden=4'hE, resp_in=4'b0001 valid for 4 cycles -> lfsr_rst high exactly 1 cycle after start; sig goes 1,3,7,E; scan_out 1,1,1,0 with scan_valid for 4 cycles; done=1, pass=1.
2. Same stimulus with golden=4'hF -> done=1, pass=0; signature=4'hE.
3. npat=4 with resp_valid gaps (valid on alternate cycles) -> same signature 4'hE; count advances only on valid cycles.
4. npat=1, resp_in=4'b1010 -> signature=4'hA; scan_out 1,0,1,0. npat=0 -> SEED then SHIFT, signature=0, pass iff golden=0.
5. rst asserted mid-RUN after 2 responses -> next cycle: state IDLE, sig=0, busy=0, done=0. A subsequent full run of scenario 1 gives pass=1.
6. start pulsed during RUN and SHIFT -> ignored. start while in DONE -> done and pass clear, new SEED pulse, run completes normally.

Source files
------------

// File: rtl/bist_misr_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bist_misr_if : control/response/scan bundle for the BIST MISR block
// Rev 1.0
// ---------------------------------------------------------------------------
interface bist_misr_if #(
  parameter int NBIT  = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] npat;
  logic [NBIT-1:0]  resp_in;
  logic             resp_valid;
  logic [NBIT-1:0]  golden;
  logic             lfsr_rst;
  logic             busy;
  logic [NBIT-1:0]  signature;
  logic             scan_out;
  logic             scan_valid;
  logic             done;
  logic             pass;

  modport master (
    output start, npat, resp_in, resp_valid, golden,
    input  lfsr_rst, busy, signature, scan_out, scan_valid, done, pass
  );

  modport slave (
    input  start, npat, resp_in, resp_valid, golden,
    output lfsr_rst, busy, signature, scan_out, scan_valid, done, pass
  );
endinterface
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bist_misr : BIST run controller, MISR response compactor and serial scan-out
// Rev 1.0
// ---------------------------------------------------------------------------
module bist_misr #(
  parameter int              NBIT  = 4,
  parameter logic [NBIT-1:0] TAPS  = NBIT'(4'b1100),
  parameter int              CNT_W = 8
) (
  input  wire logic  clk,
  input  wire logic  rst,
  bist_misr_if.slave bus
);

  localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_RUN   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [NBIT-1:0]  sig_q, sig_d;
  logic [NBIT-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] npat_q, npat_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             pass_q, pass_d;

  logic [NBIT-1:0]  fold_w;
  logic             last_w;

  assign fold_w = {sig_q[NBIT-2:0], ^(sig_q & TAPS)} ^ bus.resp_in;
  // count never exceeds npat, so the maximum npat cannot wrap the counter
  assign last_w = (count_q == (npat_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sig_q    <= '0;
      shreg_q  <= '0;
      count_q  <= '0;
      npat_q   <= '0;
      bitcnt_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      npat_q   <= npat_d;
      bitcnt_q <= bitcnt_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    npat_d   = npat_q;
    bitcnt_d = bitcnt_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SEED;
          npat_d  = bus.npat;
          sig_d   = '0;
          count_d = '0;
          pass_d  = 1'b0;
        end
      end
      S_SEED: begin
        bitcnt_d = '0;
        if (npat_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_SHIFT;
          shreg_d = sig_q;
        end
      end
      S_RUN: begin
        if (bus.resp_valid) begin
          sig_d   = fold_w;
          count_d = count_q + CNT_W'(1);
          if (last_w) begin
            shreg_d = fold_w;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        shreg_d  = {shreg_q[NBIT-2:0], 1'b0};
        bitcnt_d = bitcnt_q + BW'(1);
        if (bitcnt_q == BW'(NBIT - 1)) begin
          state_d = S_DONE;
          pass_d  = (sig_q == bus.golden);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.lfsr_rst   = (state_q == S_SEED);
  assign bus.busy       = (state_q == S_SEED) || (state_q == S_RUN) || (state_q == S_SHIFT);
  assign bus.signature  = sig_q;
  assign bus.scan_valid = (state_q == S_SHIFT);
  assign bus.scan_out   = (state_q == S_SHIFT) && shreg_q[NBIT-1];
  assign bus.done       = (state_q == S_DONE);
  assign bus.pass       = pass_q;

endmodule
`default_nettype wire
